// File: rtl/dmem_responder_if.sv
// MEM-stage data memory bus between the pipeline (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_err;

    modport master (
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata, mem_stall, mem_err
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata, mem_stall, mem_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for the MEM stage: stalls the pipeline for WAIT_STATES+1 cycles per access.
// Define DMEM_WBUF_EN to add a one-entry posted write buffer so stores never stall.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2,
    parameter int IDX_W       = 8
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t           state, state_next;
    logic [3:0]       cnt, cnt_next;
    logic [IDX_W-1:0] lat_idx;
    logic [31:0]      mem_array [DEPTH_WORDS];
    logic [31:0]      rdata_q;
    logic             err_q;
    logic             req, reject, accept, accept_fsm, complete;
    logic [IDX_W-1:0] req_idx, acc_idx;
    logic [31:0]      load_data;
`ifdef DMEM_WBUF_EN
    logic             wb_valid;
    logic [IDX_W-1:0] wb_idx;
    logic [31:0]      wb_data;
`else
    logic             lat_write, acc_write;
    logic [31:0]      lat_wdata, acc_wdata;
`endif

    assign req     = bus.mem_read | bus.mem_write;
    assign req_idx = bus.mem_addr[IDX_W+1:2];

    // The bus is only screened in IDLE; the order decides which fault wins.
    always_comb begin
        reject = 1'b0;
        accept = 1'b0;
        if (state == S_IDLE && req) begin
            if (bus.mem_read && bus.mem_write)
                reject = 1'b1;
            else if (bus.mem_addr[1:0] != 2'b00)
                reject = 1'b1;
            else if (bus.mem_addr[31:2] >= 30'(DEPTH_WORDS))
                reject = 1'b1;
            else
                accept = 1'b1;
        end
    end

`ifdef DMEM_WBUF_EN
    assign accept_fsm = accept & bus.mem_read;
`else
    assign accept_fsm = accept;
`endif

    // With zero wait states the access happens on the accepting edge, so it must use the live bus.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        complete   = 1'b0;
        acc_idx    = lat_idx;
`ifndef DMEM_WBUF_EN
        acc_write  = lat_write;
        acc_wdata  = lat_wdata;
`endif
        case (state)
            S_IDLE: begin
                if (accept_fsm) begin
                    acc_idx = req_idx;
`ifndef DMEM_WBUF_EN
                    acc_write = bus.mem_write;
                    acc_wdata = bus.mem_wdata;
`endif
                    if (WAIT_STATES > 0) begin
                        state_next = S_WAIT;
                        cnt_next   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_next = S_DONE;
                        complete   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = S_DONE;
                    complete   = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

`ifdef DMEM_WBUF_EN
    assign load_data = (wb_valid && wb_idx == acc_idx) ? wb_data : mem_array[acc_idx];
`else
    assign load_data = mem_array[acc_idx];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_idx   <= '0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
`ifdef DMEM_WBUF_EN
            wb_valid  <= 1'b0;
            wb_idx    <= '0;
            wb_data   <= 32'd0;
`else
            lat_write <= 1'b0;
            lat_wdata <= 32'd0;
`endif
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            err_q <= reject;
            if (accept_fsm) begin
                lat_idx <= req_idx;
`ifndef DMEM_WBUF_EN
                lat_write <= bus.mem_write;
                lat_wdata <= bus.mem_wdata;
`endif
            end
`ifdef DMEM_WBUF_EN
            if (complete)
                rdata_q <= load_data;
            wb_valid <= accept & bus.mem_write;
            if (accept && bus.mem_write) begin
                wb_idx  <= req_idx;
                wb_data <= bus.mem_wdata;
            end
`else
            if (complete && !acc_write)
                rdata_q <= load_data;
`endif
        end
    end

    // Array contents survive reset; the reset gate drops a store caught mid-flight.
    always_ff @(posedge clk) begin
`ifdef DMEM_WBUF_EN
        if (wb_valid)
            mem_array[wb_idx] <= wb_data;
`else
        if (reset && complete && acc_write)
            mem_array[acc_idx] <= acc_wdata;
`endif
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_err   = err_q;
    assign bus.mem_stall = reset & ((state == S_WAIT) | accept_fsm);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with WAIT_STATES=0 and one with WAIT_STATES=2.
module tb_dmem_responder;
    logic clk;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

`ifdef DMEM_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    logic [31:0] err_addr [3] = '{32'h0000_0002, 32'h0000_0400, 32'h0000_0000};
    logic        err_wr   [3] = '{1'b0, 1'b0, 1'b1};

    dmem_responder_if b0 ();
    dmem_responder_if b2 ();

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .IDX_W(8)) dut0 (
        .clk(clk), .reset(reset), .bus(b0));
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .IDX_W(8)) dut2 (
        .clk(clk), .reset(reset), .bus(b2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] stall_of(input int sel);
        return (sel == 0) ? {31'd0, b0.mem_stall} : {31'd0, b2.mem_stall};
    endfunction

    function automatic logic [31:0] err_of(input int sel);
        return (sel == 0) ? {31'd0, b0.mem_err} : {31'd0, b2.mem_err};
    endfunction

    function automatic logic [31:0] rdata_of(input int sel);
        return (sel == 0) ? b0.mem_rdata : b2.mem_rdata;
    endfunction

    function automatic int store_stall(input int ws);
        return WBUF ? 0 : ws + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic rd, input logic wr);
        if (sel == 0) begin
            b0.mem_addr = addr; b0.mem_wdata = wdata; b0.mem_read = rd; b0.mem_write = wr;
        end else begin
            b2.mem_addr = addr; b2.mem_wdata = wdata; b2.mem_read = rd; b2.mem_write = wr;
        end
    endtask

    task automatic idle_all();
        drive(0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(2, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Holds the request through the stall like the pipeline would, then checks the DONE cycle.
    task automatic access(input int sel, input string tag, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic rd, input logic wr,
                          input int exp_stall, input logic chk_rd, input logic [31:0] exp_rd);
        int n;
        drive(sel, addr, wdata, rd, wr);
        #1;
        n = 0;
        while (stall_of(sel) == 32'd1 && n < 40) begin
            n++;
            tick();
        end
        check({tag, " stall cycles"}, 32'(n), 32'(exp_stall));
        check({tag, " err"}, err_of(sel), 32'd0);
        if (chk_rd)
            check({tag, " rdata"}, rdata_of(sel), exp_rd);
        tick();
    endtask

    initial begin
        reset = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        check("reset rdata", rdata_of(2), 32'd0);
        check("reset stall", stall_of(2), 32'd0);
        check("reset err", err_of(2), 32'd0);
        check("reset rdata ws0", rdata_of(0), 32'd0);
        reset = 1'b1;
        tick();

        $display("[TB] WAIT_STATES=2 store/load and back-to-back loads");
        access(2, "st 0x00", 32'h00, 32'h1111_1111, 1'b0, 1'b1, store_stall(2), 1'b0, 32'd0);
        access(2, "st 0x04", 32'h04, 32'h2222_2222, 1'b0, 1'b1, store_stall(2), 1'b0, 32'd0);
        access(2, "st 0x10", 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, store_stall(2), 1'b0, 32'd0);
        access(2, "ld 0x10", 32'h10, 32'd0, 1'b1, 1'b0, 3, 1'b1, 32'hDEAD_BEEF);
        access(2, "b2b ld 0x00", 32'h00, 32'd0, 1'b1, 1'b0, 3, 1'b1, 32'h1111_1111);
        access(2, "b2b ld 0x04", 32'h04, 32'd0, 1'b1, 1'b0, 3, 1'b1, 32'h2222_2222);
        idle_all();
        #1;
        check("post b2b stall", stall_of(2), 32'd0);
        check("post b2b rdata held", rdata_of(2), 32'h2222_2222);
        tick();

        $display("[TB] rejected requests");
        for (int i = 0; i < 3; i++) begin
            drive(2, err_addr[i], 32'hBAD0_BAD0, 1'b1, err_wr[i]);
            #1;
            check($sformatf("err%0d req stall", i), stall_of(2), 32'd0);
            tick();
            idle_all();
            #1;
            check($sformatf("err%0d pulse", i), err_of(2), 32'd1);
            check($sformatf("err%0d stall", i), stall_of(2), 32'd0);
            check($sformatf("err%0d rdata", i), rdata_of(2), 32'h2222_2222);
            tick();
            check($sformatf("err%0d pulse end", i), err_of(2), 32'd0);
        end
        access(2, "ld 0x00 after err", 32'h00, 32'd0, 1'b1, 1'b0, 3, 1'b1, 32'h1111_1111);

        $display("[TB] WAIT_STATES=0 access");
        access(0, "ws0 st 0x04", 32'h04, 32'h1234_5678, 1'b0, 1'b1, store_stall(0), 1'b0, 32'd0);
        access(0, "ws0 ld 0x04", 32'h04, 32'd0, 1'b1, 1'b0, 1, 1'b1, 32'h1234_5678);
        idle_all();
        #1;
        check("ws0 idle stall", stall_of(0), 32'd0);
        tick();

        $display("[TB] store then immediate load");
        access(0, "ws0 st 0x30", 32'h30, 32'h55AA_55AA, 1'b0, 1'b1, store_stall(0), 1'b0, 32'd0);
        access(0, "ws0 ld 0x30", 32'h30, 32'd0, 1'b1, 1'b0, 1, 1'b1, 32'h55AA_55AA);
        access(0, "ws0 reld 0x30", 32'h30, 32'd0, 1'b1, 1'b0, 1, 1'b1, 32'h55AA_55AA);
        access(2, "st 0x30", 32'h30, 32'h55AA_55AA, 1'b0, 1'b1, store_stall(2), 1'b0, 32'd0);
        access(2, "ld 0x30", 32'h30, 32'd0, 1'b1, 1'b0, 3, 1'b1, 32'h55AA_55AA);
        idle_all();
        tick();

`ifndef DMEM_WBUF_EN
        $display("[TB] reset during WAIT");
        access(2, "st 0x20", 32'h20, 32'hAAAA_0000, 1'b0, 1'b1, 3, 1'b0, 32'd0);
        drive(2, 32'h20, 32'hCAFE_F00D, 1'b0, 1'b1);
        #1;
        check("rst accept stall", stall_of(2), 32'd1);
        tick();
        check("rst wait stall", stall_of(2), 32'd1);
        reset = 1'b0;
        #1;
        check("rst stall", stall_of(2), 32'd0);
        check("rst rdata", rdata_of(2), 32'd0);
        check("rst err", err_of(2), 32'd0);
        tick();
        check("rst held stall", stall_of(2), 32'd0);
        tick();
        idle_all();
        reset = 1'b1;
        #1;
        check("rst release stall", stall_of(2), 32'd0);
        tick();
        access(2, "ld 0x20 after rst", 32'h20, 32'd0, 1'b1, 1'b0, 3, 1'b1, 32'hAAAA_0000);
        idle_all();
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
